utf8_byte_serializer: RTL and testbench
=======================================

UTF8_BYTE_SERIALIZER -- requirements
Module: utf8_byte_serializer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 6, giving the longest sequence emitted; legal values are 4 or 6.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port chk_range, input, 1 bit: when high, reject code points above 0x10FFFF and surrogates 0xD800-0xDFFF.
REQ-005 SHALL have port cp_in, input, 31 bits: code point offered.
REQ-006 SHALL have port cp_valid, input, 1 bit: cp_in is offered.
REQ-007 SHALL have port cp_ready, output, 1 bit: block accepts cp_in this cycle.
REQ-008 SHALL have port byte_out, output, 8 bits: current UTF-8 byte.
REQ-009 SHALL have port byte_valid, output, 1 bit: byte_out is valid.
REQ-010 SHALL have port byte_ready, input, 1 bit: sink accepts byte_out.
REQ-011 SHALL have port byte_last, output, 1 bit: byte_out is the final byte of its sequence.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse for a rejected code point.
REQ-013 SHALL have port err_count, output, 8 bits: saturating count of rejected code points.

Function
REQ-014 SHALL complete a code point transfer when cp_valid and cp_ready are both high on a clock edge, and a byte transfer when byte_valid and byte_ready are both high on a clock edge.
REQ-015 SHALL drive cp_ready = (state IDLE) | (byte_valid & byte_last & byte_ready); this combinational path from byte_ready is intended, giving back-to-back sequences with no bubble.
REQ-016 SHALL set sequence length from the accepted value: <0x80 gives 1; <0x800 gives 2; <0x10000 gives 3; <0x200000 gives 4; <0x4000000 gives 5; otherwise 6.
REQ-017 SHALL reject a code point when chk_range=1 and it is >0x10FFFF or in 0xD800-0xDFFF, or when MAX_BYTES=4 and it is >=0x200000.
REQ-018 SHALL, on rejection, pulse err high for the cycle after acceptance, emit no bytes, stay in IDLE, and increment err_count saturating at 0xFF.
REQ-019 SHALL present the lead byte, registered, in the cycle after acceptance, using the standard lead-byte prefix for the length: 0xxxxxxx, 110xxxxx, 1110xxxx, 11110xxx, 111110xx or 1111110x, filled with the highest payload bits.
REQ-020 SHALL follow the lead byte with 10xxxxxx continuation bytes, most-significant 6-bit group first, advancing one byte per completed byte transfer.
REQ-021 SHALL hold byte_out, byte_valid and byte_last stable while byte_valid=1 and byte_ready=0.
REQ-022 SHALL implement states IDLE and EMIT with a 3-bit remaining-byte counter and a 31-bit shift/hold register:
- IDLE to EMIT on a valid accept.
- EMIT to IDLE on a last-byte transfer with no new accept.
- EMIT to EMIT (reloaded) on a last-byte transfer with a simultaneous new accept.
REQ-023 SHALL, when a rejected code point is accepted in the same cycle as a last-byte transfer, go to IDLE and pulse err.
REQ-024 SHALL ignore cp_in when cp_valid=0 and SHALL ignore byte_ready when byte_valid=0.

Reset
REQ-025 SHALL, while rst is high, force the following, asynchronously and discarding any partial sequence:
- state IDLE;
- byte_valid=0, byte_last=0, byte_out=0x00;
- err=0, err_count=0;
- cp_ready=0.
REQ-026 SHALL drive cp_ready=1 in the first cycle after rst deasserts.

Structure
REQ-027 SHALL place the state enum, the length thresholds (0x80, 0x800, 0x10000, 0x200000, 0x4000000), the surrogate bounds and 0x10FFFF in a shared package, utf8_pkg.
REQ-028 SHALL place length computation and range checking in one combinational sub-module, utf8_cp_classify (inputs cp and chk_range; outputs len and reject), which the team's future decoder reuses.

Verification
REQ-029 SHALL cover: cp 0x41 with byte_ready=1 -> one byte 0x41 with byte_last=1, one cycle after accept.
REQ-030 SHALL cover: cp 0x20AC, byte_ready=1 -> E2, 82, AC on consecutive cycles, byte_last only on AC.
REQ-031 SHALL cover: cp 0x1F600 with byte_ready toggling 1,0,0,1,... -> F0 9F 98 80, each byte held stable through stalls.
REQ-032 SHALL cover surrogate handling:
- chk_range=1, cp 0xD800 -> err one pulse, no byte_valid, err_count=1.
- chk_range=0, cp 0xD800 -> ED A0 80.
REQ-033 SHALL cover long code points:
- chk_range=0, MAX_BYTES=6, cp 0x7FFFFFFF -> FD BF BF BF BF BF.
- Same stimulus with MAX_BYTES=4 -> err, no bytes.
REQ-034 SHALL cover:
- cp 0x41 then 0xE9 held valid -> 41, C3, A9 with no idle cycle.
- rst asserted mid-EMIT -> byte_valid=0 immediately; first post-reset output is the next accepted code point.

Source files
------------

// File: rtl/utf8_pkg.sv
// Shared definitions for the UTF-8 serializer and the classifier it uses.
// Holds the FSM state type, the sequence-length thresholds, the range-check
// bounds and helpers that build lead and continuation bytes.
package utf8_pkg;

    typedef enum logic {StIdle, StEmit} state_e;

    localparam int unsigned CpW = 31;

    // Smallest code point that needs 2..6 bytes.
    localparam logic [30:0] Len2Min = 31'h80;
    localparam logic [30:0] Len3Min = 31'h800;
    localparam logic [30:0] Len4Min = 31'h10000;
    localparam logic [30:0] Len5Min = 31'h200000;
    localparam logic [30:0] Len6Min = 31'h4000000;

    localparam logic [30:0] SurrLo = 31'hD800;
    localparam logic [30:0] SurrHi = 31'hDFFF;
    localparam logic [30:0] CpMax  = 31'h10FFFF;

    // Lead byte for a sequence of len bytes, carrying the highest payload bits.
    function automatic logic [7:0] lead_byte(input logic [30:0] cp, input logic [2:0] len);
        logic [7:0] b;
        case (len)
            3'd1:    b = {1'b0, cp[6:0]};
            3'd2:    b = {3'b110, cp[10:6]};
            3'd3:    b = {4'b1110, cp[15:12]};
            3'd4:    b = {5'b11110, cp[20:18]};
            3'd5:    b = {6'b111110, cp[25:24]};
            default: b = {7'b1111110, cp[30]};
        endcase
        return b;
    endfunction

    // Continuation byte carrying 6-bit group idx (0 = least significant).
    function automatic logic [7:0] cont_byte(input logic [30:0] cp, input logic [2:0] idx);
        logic [30:0] sh;
        sh = cp >> (5'(idx) * 5'd6);
        return {2'b10, sh[5:0]};
    endfunction

endpackage

// File: rtl/utf8_byte_serializer_if.sv
// Handshake bundle for the serializer: code point input stream and byte output
// stream. slave = serializer side, master = producer/consumer side.
//   cp_in/cp_valid/cp_ready           : code point offer and acceptance
//   byte_out/byte_valid/byte_ready    : UTF-8 byte stream
//   byte_last                         : final byte of a sequence
interface utf8_byte_serializer_if;
    import utf8_pkg::*;

    logic [CpW-1:0] cp_in;
    logic           cp_valid;
    logic           cp_ready;
    logic [7:0]     byte_out;
    logic           byte_valid;
    logic           byte_ready;
    logic           byte_last;

    modport slave (
        input  cp_in, cp_valid, byte_ready,
        output cp_ready, byte_out, byte_valid, byte_last
    );

    modport master (
        output cp_in, cp_valid, byte_ready,
        input  cp_ready, byte_out, byte_valid, byte_last
    );
endinterface

// File: rtl/utf8_cp_classify.sv
// Combinational code point classifier, shared with the decoder.
//   cp        : code point
//   chk_range : enable rejection of >0x10FFFF and surrogates
//   len       : UTF-8 sequence length, 1..6
//   reject    : code point fails the range check
module utf8_cp_classify
    import utf8_pkg::*;
(
    input  logic [30:0] cp,
    input  logic        chk_range,
    output logic [2:0]  len,
    output logic        reject
);

    always_comb begin
        len = 3'd6;
        if (cp < Len2Min) begin
            len = 3'd1;
        end else if (cp < Len3Min) begin
            len = 3'd2;
        end else if (cp < Len4Min) begin
            len = 3'd3;
        end else if (cp < Len5Min) begin
            len = 3'd4;
        end else if (cp < Len6Min) begin
            len = 3'd5;
        end
    end

    always_comb begin
        reject = chk_range && ((cp > CpMax) || ((cp >= SurrLo) && (cp <= SurrHi)));
    end

endmodule

// File: rtl/utf8_byte_serializer.sv
// Serializes 31-bit code points into a UTF-8 byte stream with valid/ready on
// both sides. Rejected code points produce an err pulse and bump err_count.
//   clk, rst  : clock, asynchronous active-high reset
//   chk_range : reject >0x10FFFF and surrogates
//   bus       : code point / byte handshake bundle (slave side)
//   err       : one-cycle pulse per rejected code point
//   err_count : saturating rejection count
module utf8_byte_serializer
    import utf8_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          chk_range,
    utf8_byte_serializer_if.slave         bus,
    output logic                          err,
    output logic [7:0]                    err_count
);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [30:0] hold_q;
    logic [7:0]  byte_out_q;
    logic        byte_valid_q;
    logic        byte_last_q;
    logic        err_q;
    logic [7:0]  err_count_q;

    logic [2:0]  cp_len;
    logic        cp_range_rej;
    logic        cp_reject;
    logic        cp_accept;
    logic        byte_xfer;

    utf8_cp_classify u_classify (
        .cp        (bus.cp_in),
        .chk_range (chk_range),
        .len       (cp_len),
        .reject    (cp_range_rej)
    );

    always_comb begin
        cp_reject = cp_range_rej || ((MAX_BYTES == 4) && (cp_len > 3'd4));
        byte_xfer = byte_valid_q && bus.byte_ready;
        // Accept while the last byte leaves so sequences run back to back.
        bus.cp_ready = !rst && ((state_q == StIdle) || (byte_xfer && byte_last_q));
        cp_accept = bus.cp_valid && bus.cp_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            hold_q       <= '0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= 8'h00;
        end else begin
            err_q <= 1'b0;
            if (byte_xfer) begin
                if (byte_last_q) begin
                    state_q      <= StIdle;
                    byte_valid_q <= 1'b0;
                    byte_last_q  <= 1'b0;
                end else begin
                    // cnt_q counts continuation bytes still to send.
                    byte_out_q  <= cont_byte(hold_q, cnt_q - 3'd1);
                    cnt_q       <= cnt_q - 3'd1;
                    byte_last_q <= (cnt_q == 3'd1);
                end
            end
            if (cp_accept) begin
                if (cp_reject) begin
                    err_q <= 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_q <= err_count_q + 8'd1;
                    end
                end else begin
                    state_q      <= StEmit;
                    hold_q       <= bus.cp_in;
                    cnt_q        <= cp_len - 3'd1;
                    byte_out_q   <= lead_byte(bus.cp_in, cp_len);
                    byte_valid_q <= 1'b1;
                    byte_last_q  <= (cp_len == 3'd1);
                end
            end
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_last  = byte_last_q;
    assign err            = err_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_utf8_byte_serializer.sv
module tb_utf8_byte_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       chk = 1'b0;
    logic       err6, err4;
    logic [7:0] errc6, errc4;

    int checks   = 0;
    int failures = 0;
    int exp_errs = 0;

    utf8_byte_serializer_if if6();
    utf8_byte_serializer_if if4();

    utf8_byte_serializer #(.MAX_BYTES(6)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .chk_range (chk),
        .bus       (if6),
        .err       (err6),
        .err_count (errc6)
    );

    utf8_byte_serializer #(.MAX_BYTES(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .chk_range (chk),
        .bus       (if4),
        .err       (err4),
        .err_count (errc4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] cp;
        logic        chk;
        int          n;
        logic [47:0] bytes;  // first byte in bits [47:40]
        logic        err;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Offer one code point with byte_ready held high and check its byte stream.
    task automatic do_vec(input int i);
        vec_t v;
        logic [7:0] eb;
        v = vecs[i];
        chk = v.chk;
        if6.cp_in = v.cp;
        if6.cp_valid = 1'b1;
        if6.byte_ready = 1'b1;
        #1;
        check($sformatf("v%0d cp_ready idle", i), {31'd0, if6.cp_ready}, 32'd1);
        @(posedge clk);
        #1;
        if6.cp_valid = 1'b0;
        check($sformatf("v%0d err", i), {31'd0, err6}, {31'd0, v.err});
        for (int k = 0; k < v.n; k++) begin
            eb = v.bytes[8*(5-k) +: 8];
            check($sformatf("v%0d byte%0d {valid,last,out}", i, k),
                  {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out},
                  {22'd0, 1'b1, (k == v.n - 1), eb});
            cyc();
        end
        check($sformatf("v%0d idle after", i), {31'd0, if6.byte_valid}, 32'd0);
        if (v.err && exp_errs < 255) exp_errs++;
        check($sformatf("v%0d err_count", i), {24'd0, errc6}, exp_errs);
    endtask

    initial begin
        logic [7:0] got[$];
        logic       pv, pl, pr;
        logic [7:0] pb;
        logic       done;

        vecs[0]  = '{31'h41,       1'b1, 1, 48'h41_00_00_00_00_00, 1'b0};
        vecs[1]  = '{31'h20AC,     1'b1, 3, 48'hE2_82_AC_00_00_00, 1'b0};
        vecs[2]  = '{31'hE9,       1'b0, 2, 48'hC3_A9_00_00_00_00, 1'b0};
        vecs[3]  = '{31'hD800,     1'b1, 0, 48'h0,                 1'b1};
        vecs[4]  = '{31'hD800,     1'b0, 3, 48'hED_A0_80_00_00_00, 1'b0};
        vecs[5]  = '{31'h7FFFFFFF, 1'b0, 6, 48'hFD_BF_BF_BF_BF_BF, 1'b0};
        vecs[6]  = '{31'h10FFFF,   1'b1, 4, 48'hF4_8F_BF_BF_00_00, 1'b0};
        vecs[7]  = '{31'h110000,   1'b1, 0, 48'h0,                 1'b1};
        vecs[8]  = '{31'h110000,   1'b0, 4, 48'hF4_90_80_80_00_00, 1'b0};
        vecs[9]  = '{31'h7FF,      1'b0, 2, 48'hDF_BF_00_00_00_00, 1'b0};
        vecs[10] = '{31'h800,      1'b0, 3, 48'hE0_A0_80_00_00_00, 1'b0};
        vecs[11] = '{31'hFFFF,     1'b0, 3, 48'hEF_BF_BF_00_00_00, 1'b0};
        vecs[12] = '{31'h200000,   1'b0, 5, 48'hF8_88_80_80_80_00, 1'b0};
        vecs[13] = '{31'h3FFFFFF,  1'b0, 5, 48'hFB_BF_BF_BF_BF_00, 1'b0};
        vecs[14] = '{31'h4000000,  1'b0, 6, 48'hFC_84_80_80_80_80, 1'b0};
        vecs[15] = '{31'hDFFF,     1'b1, 0, 48'h0,                 1'b1};
        vecs[16] = '{31'hE000,     1'b1, 3, 48'hEE_80_80_00_00_00, 1'b0};
        vecs[17] = '{31'h7F,       1'b0, 1, 48'h7F_00_00_00_00_00, 1'b0};
        vecs[18] = '{31'h80,       1'b0, 2, 48'hC2_80_00_00_00_00, 1'b0};

        if6.cp_in = '0;  if6.cp_valid = 1'b0;  if6.byte_ready = 1'b1;
        if4.cp_in = '0;  if4.cp_valid = 1'b0;  if4.byte_ready = 1'b1;

        // Reset state
        #3;
        check("rst byte_valid", {31'd0, if6.byte_valid}, 32'd0);
        check("rst byte_out", {24'd0, if6.byte_out}, 32'd0);
        check("rst cp_ready", {31'd0, if6.cp_ready}, 32'd0);
        check("rst err/err_count", {23'd0, err6, errc6}, 32'd0);
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        check("cp_ready after reset", {31'd0, if6.cp_ready}, 32'd1);
        cyc();

        for (int i = 0; i < 19; i++) do_vec(i);

        // Stalled sink: ready pattern 1,0,0,1,0,0...
        chk = 1'b0;
        if6.cp_in = 31'h1F600;
        if6.cp_valid = 1'b1;
        if6.byte_ready = 1'b1;
        cyc();
        if6.cp_valid = 1'b0;
        pv = 1'b0; pl = 1'b0; pr = 1'b1; pb = 8'h00;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (pv && !pr) begin
                check($sformatf("stall hold c%0d", c),
                      {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out},
                      {22'd0, pv, pl, pb});
            end
            if6.byte_ready = (c % 3 == 0);
            if (if6.byte_valid && if6.byte_ready) begin
                got.push_back(if6.byte_out);
                if (if6.byte_last) done = 1'b1;
            end
            pv = if6.byte_valid; pl = if6.byte_last; pb = if6.byte_out; pr = if6.byte_ready;
            cyc();
        end
        if6.byte_ready = 1'b1;
        check("stall byte count", got.size(), 32'd4);
        if (got.size() == 4) begin
            check("stall bytes", {got[0], got[1], got[2], got[3]}, 32'hF09F9880);
        end
        check("stall idle after", {31'd0, if6.byte_valid}, 32'd0);

        // Back-to-back 0x41 then 0xE9 with no bubble
        if6.cp_in = 31'h41;
        if6.cp_valid = 1'b1;
        cyc();
        if6.cp_in = 31'hE9;
        check("b2b 41", {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out}, {22'd0, 2'b11, 8'h41});
        #1;
        check("b2b cp_ready on last", {31'd0, if6.cp_ready}, 32'd1);
        cyc();
        if6.cp_valid = 1'b0;
        check("b2b C3", {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out}, {22'd0, 2'b10, 8'hC3});
        cyc();
        check("b2b A9", {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out}, {22'd0, 2'b11, 8'hA9});
        cyc();
        check("b2b idle", {31'd0, if6.byte_valid}, 32'd0);

        // Rejected code point accepted during the last-byte transfer
        chk = 1'b1;
        if6.cp_in = 31'h41;
        if6.cp_valid = 1'b1;
        cyc();
        if6.cp_in = 31'hD800;
        check("rej-on-last 41", {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out}, {22'd0, 2'b11, 8'h41});
        cyc();
        if6.cp_valid = 1'b0;
        exp_errs++;
        check("rej-on-last err,valid", {30'd0, err6, if6.byte_valid}, 32'd2);
        cyc();
        check("rej-on-last err_count", {24'd0, errc6}, exp_errs);
        check("rej-on-last cp_ready", {31'd0, if6.cp_ready}, 32'd1);

        // MAX_BYTES=4 instance
        chk = 1'b0;
        if4.cp_in = 31'h7FFFFFFF;
        if4.cp_valid = 1'b1;
        cyc();
        if4.cp_valid = 1'b0;
        check("max4 err,valid", {30'd0, err4, if4.byte_valid}, 32'd2);
        cyc();
        check("max4 err_count", {24'd0, errc4}, 32'd1);
        if4.cp_in = 31'h1FFFFF;
        if4.cp_valid = 1'b1;
        cyc();
        if4.cp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("max4 1FFFFF byte%0d", k),
                  {22'd0, if4.byte_valid, if4.byte_last, if4.byte_out},
                  {22'd0, 1'b1, (k == 3), (k == 0) ? 8'hF7 : 8'hBF});
            cyc();
        end

        // err_count saturation
        chk = 1'b1;
        if6.cp_in = 31'h110000;
        if6.cp_valid = 1'b1;
        for (int c = 0; c < 260; c++) cyc();
        if6.cp_valid = 1'b0;
        cyc();
        exp_errs = 255;
        check("err_count saturates", {24'd0, errc6}, exp_errs);

        // Reset mid-EMIT
        chk = 1'b0;
        if6.cp_in = 31'h7FFFFFFF;
        if6.cp_valid = 1'b1;
        cyc();
        if6.cp_valid = 1'b0;
        cyc();
        if6.byte_ready = 1'b0;
        check("pre-reset mid sequence", {22'd0, if6.byte_valid, if6.byte_last, if6.byte_out},
              {22'd0, 2'b10, 8'hBF});
        #2;
        rst = 1'b1;
        #1;
        check("mid-reset byte_valid", {31'd0, if6.byte_valid}, 32'd0);
        check("mid-reset byte_out", {24'd0, if6.byte_out}, 32'd0);
        check("mid-reset cp_ready", {31'd0, if6.cp_ready}, 32'd0);
        check("mid-reset err_count", {24'd0, errc6}, 32'd0);
        exp_errs = 0;
        cyc();
        #2;
        rst = 1'b0;
        if6.byte_ready = 1'b1;
        #1;
        check("post-reset cp_ready", {31'd0, if6.cp_ready}, 32'd1);
        cyc();
        check("post-reset no stale byte", {31'd0, if6.byte_valid}, 32'd0);
        do_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
